// File: rtl/bcd_display_driver_pkg.sv
// Shared constants, converter state encoding and elaboration-time helpers
// for the multiplexed BCD display driver.
package display_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } conv_state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_display_driver_if.sv
// Valid/ready channel carrying a binary value into the display driver.
interface bcd_display_driver_if #(
    parameter int BIN_W = 14
);

    logic             bin_valid;
    logic [BIN_W-1:0] bin_in;
    logic             bin_ready;

    modport master (
        output bin_valid,
        output bin_in,
        input  bin_ready
    );

    modport slave (
        input  bin_valid,
        input  bin_in,
        output bin_ready
    );

endinterface

// File: rtl/bcd_display_driver_bin_to_bcd_seq.sv
// Sequential double-dabble converter: accepts one value per handshake,
// produces packed BCD plus an overflow flag with a one-cycle done pulse.
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_display_driver_if.slave  bin_bus,
    output logic [4*DIGITS-1:0]  bcd_word,
    output logic                 ovf,
    output logic                 done
);

    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    conv_state_t         state;
    conv_state_t         state_next;
    logic [BIN_W-1:0]    bin_sr;
    logic [BIN_W-1:0]    bin_sr_next;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] scratch_next;
    logic [4*DIGITS-1:0] adjusted;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_next;
    logic                ovf_cap;
    logic                ovf_cap_next;
    logic                accept;

    assign bin_bus.bin_ready = (state == IDLE);
    assign accept            = bin_bus.bin_valid && (state == IDLE);

    assign bcd_word = scratch;
    assign ovf      = ovf_cap;
    assign done     = (state == LATCH);

    // Add-3 correction on every nibble that would exceed 9 after doubling
    always_comb begin
        adjusted = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_next   = state;
        bin_sr_next  = bin_sr;
        scratch_next = scratch;
        bit_cnt_next = bit_cnt;
        ovf_cap_next = ovf_cap;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = SHIFT;
                    bin_sr_next  = bin_bus.bin_in;
                    scratch_next = '0;
                    bit_cnt_next = CNT_W'(BIN_W);
                    ovf_cap_next = (64'(bin_bus.bin_in) >= LIMIT);
                end
            end
            SHIFT: begin
                {scratch_next, bin_sr_next} = {adjusted, bin_sr} << 1;
                bit_cnt_next = bit_cnt - CNT_W'(1);
                if (bit_cnt == CNT_W'(1)) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bin_sr  <= '0;
            scratch <= '0;
            bit_cnt <= '0;
            ovf_cap <= 1'b0;
        end else begin
            state   <= state_next;
            bin_sr  <= bin_sr_next;
            scratch <= scratch_next;
            bit_cnt <= bit_cnt_next;
            ovf_cap <= ovf_cap_next;
        end
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Multi-digit display feeder: binary-to-BCD conversion, atomic display
// register, leading-zero blanking and time-multiplexed digit scanning.
module bcd_display_driver
    import display_pkg::*;
#(
    parameter int BIN_W         = 14,
    parameter int DIGITS        = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_display_driver_if.slave bin_bus,
    output logic [3:0]          digit_bcd,
    output logic [DIGITS-1:0]   digit_en,
    output logic                overflow
);

    localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] conv_word;
    logic                conv_ovf;
    logic                conv_done;
    logic [4*DIGITS-1:0] display;
    logic [RC_W-1:0]     refresh_cnt;
    logic [IDX_W-1:0]    scan_idx;
    logic [DIGITS-1:0]   zero_from;
    logic [3:0]          raw_digit;

    bin_to_bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin_bus  (bin_bus),
        .bcd_word (conv_word),
        .ovf      (conv_ovf),
        .done     (conv_done)
    );

    // Whole-word update so the scanner never shows a half-old, half-new value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            display  <= '0;
            overflow <= 1'b0;
        end else if (conv_done) begin
            display  <= conv_ovf ? {DIGITS{BCD_BLANK}} : conv_word;
            overflow <= conv_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == RC_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            refresh_cnt <= refresh_cnt + RC_W'(1);
        end
    end

    // zero_from[k] is set when digit k and every more significant digit are zero
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (display[4*(DIGITS-1) +: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (display[4*k +: 4] == 4'd0);
        end
    end

    always_comb begin
        raw_digit          = display[{scan_idx, 2'b00} +: 4];
        digit_en           = '0;
        digit_en[scan_idx] = 1'b1;
        digit_bcd          = raw_digit;
        if ((BLANK_LEADING != 0) && (scan_idx != '0) && zero_from[scan_idx]) begin
            digit_bcd = BCD_BLANK;
        end
    end

endmodule
